digit_match_sched: RTL and testbench

- Sequences the recognition read port shared by the ten 16x16 digit glyph ROMs (prom_0..prom_9). Each ROM's display port is not touched by this block.
- Compares every template row against the captured 16x16 binarised image, one row per cycle. Accumulates a per-digit bit-match score and reports the best-matching digit.
- Sits between the image capture buffer and the result/7-seg display logic, using a start/done handshake.

---
 rtl/digit_match_pkg.sv | 29 ++
 rtl/row_popcount.sv | 15 +
 rtl/digit_match_sched.sv | 208 ++++++++++++++++++++
 tb/tb_digit_match_sched.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_match_pkg.sv
// Shared constants, FSM state type and the row-popcount helper used by the
// digit template matcher.
package digit_match_pkg;

   localparam int ROWS    = 16;
   localparam int ROW_W   = 16;
   localparam int SCORE_W = 9;
   localparam int DIGIT_W = 4;
   localparam int MATCH_W = 5;

   localparam logic [SCORE_W-1:0] MIN_SCORE_DEF = 9'd192;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic logic [MATCH_W-1:0] popcount16(input logic [ROW_W-1:0] v);
      logic [MATCH_W-1:0] cnt;
      cnt = 5'd0;
      for (int i = 0; i < ROW_W; i++) begin
         cnt = cnt + {4'd0, v[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/row_popcount.sv
// Number of agreeing pixels between one template row and one image row (0..16).
module row_popcount
   import digit_match_pkg::*;
(
   input  logic [ROW_W-1:0]   i_tmpl,
   input  logic [ROW_W-1:0]   i_img,
   output logic [MATCH_W-1:0] o_match
);

   // XNOR marks agreeing pixels, popcount sums them
   always_comb begin
      o_match = popcount16(~(i_tmpl ^ i_img));
   end

endmodule

// File: rtl/digit_match_sched.sv
// Scans all digit templates against the captured image row by row and reports
// the best-matching digit. Optional per-digit score readback: DIGIT_SCORES_EN.
module digit_match_sched
   import digit_match_pkg::*;
#(
   parameter int                 NUM_DIGITS = 10,
   parameter logic [SCORE_W-1:0] MIN_SCORE  = MIN_SCORE_DEF
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   output logic [DIGIT_W-1:0] rom_sel,
   output logic [3:0]         rom_addr,
   input  logic [ROW_W-1:0]   tmpl_row,
   output logic [3:0]         img_addr,
   input  logic [ROW_W-1:0]   img_row,
   output logic               busy,
   output logic               done,
   output logic [DIGIT_W-1:0] digit,
   output logic [SCORE_W-1:0] score,
   output logic               no_match
`ifdef DIGIT_SCORES_EN
   ,
   input  logic [DIGIT_W-1:0] score_rd_sel,
   output logic [SCORE_W-1:0] score_rd
`endif
);

   localparam logic [DIGIT_W-1:0] LAST_SEL = DIGIT_W'(NUM_DIGITS - 1);

   state_t               r_state;
   state_t               w_next;
   logic [DIGIT_W-1:0]   r_sel;
   logic [3:0]           r_addr;
   logic [MATCH_W-1:0]   w_match;
   logic                 w_last_issue;
   logic                 w_scan_start;

   logic                 r_s1_vld;
   logic                 r_s1_last;
   logic [MATCH_W-1:0]   r_s1_match;
   logic [DIGIT_W-1:0]   r_s1_digit;

   logic [SCORE_W-1:0]   r_acc;
   logic [SCORE_W-1:0]   r_best_score;
   logic [DIGIT_W-1:0]   r_best_digit;
   logic [SCORE_W-1:0]   w_total;
   logic                 w_upd;
   logic [SCORE_W-1:0]   w_final_score;
   logic [DIGIT_W-1:0]   w_final_digit;

   logic [DIGIT_W-1:0]   r_digit;
   logic [SCORE_W-1:0]   r_score;
   logic                 r_no_match;

   row_popcount u_row_popcount (
      .i_tmpl  (tmpl_row),
      .i_img   (img_row),
      .o_match (w_match)
   );

   assign w_last_issue = (r_sel == LAST_SEL) && (r_addr == 4'd15);
   assign w_scan_start = ((r_state == IDLE) || (r_state == DONE)) && (w_next == SCAN);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; abort overrides everything including a same-cycle start
   always_comb begin
      w_next = r_state;
      if (abort) begin
         w_next = IDLE;
      end else begin
         case (r_state)
            IDLE:    w_next = start ? SCAN : IDLE;
            SCAN:    w_next = w_last_issue ? FLUSH : SCAN;
            FLUSH:   w_next = DONE;
            DONE:    w_next = start ? SCAN : IDLE;
            default: w_next = IDLE;
         endcase
      end
   end

   // FSM-decoded outputs
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         IDLE:    begin busy = 1'b0; done = 1'b0; end
         SCAN:    begin busy = 1'b1; done = 1'b0; end
         FLUSH:   begin busy = 1'b1; done = 1'b0; end
         DONE:    begin busy = 1'b1; done = 1'b1; end
         default: begin busy = 1'b0; done = 1'b0; end
      endcase
   end

   // Issue counters; held at zero outside an ongoing scan
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel  <= 4'd0;
         r_addr <= 4'd0;
      end else if ((r_state == SCAN) && (w_next == SCAN)) begin
         r_addr <= r_addr + 4'd1;
         if (r_addr == 4'd15) begin
            r_sel <= r_sel + 4'd1;
         end
      end else begin
         r_sel  <= 4'd0;
         r_addr <= 4'd0;
      end
   end

   // Stage 1: registered row match with its digit/last-row tags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_vld   <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s1_match <= 5'd0;
         r_s1_digit <= 4'd0;
      end else begin
         r_s1_vld   <= (r_state == SCAN) && !abort;
         r_s1_last  <= (r_addr == 4'd15);
         r_s1_match <= w_match;
         r_s1_digit <= r_sel;
      end
   end

   assign w_total       = r_acc + {4'd0, r_s1_match};
   assign w_upd         = r_s1_vld && r_s1_last && (w_total > r_best_score);
   assign w_final_score = w_upd ? w_total : r_best_score;
   assign w_final_digit = w_upd ? r_s1_digit : r_best_digit;

   // Stage 2: per-digit accumulation and strict-greater best tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc        <= 9'd0;
         r_best_score <= 9'd0;
         r_best_digit <= 4'd0;
      end else if (abort || w_scan_start) begin
         r_acc        <= 9'd0;
         r_best_score <= 9'd0;
         r_best_digit <= 4'd0;
      end else if (r_s1_vld) begin
         r_acc        <= r_s1_last ? 9'd0 : w_total;
         r_best_score <= w_final_score;
         r_best_digit <= w_final_digit;
      end
   end

   // Result registers; the final row drains during FLUSH so its total is folded in here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_digit    <= 4'd0;
         r_score    <= 9'd0;
         r_no_match <= 1'b1;
      end else if ((r_state == FLUSH) && !abort) begin
         r_digit    <= w_final_digit;
         r_score    <= w_final_score;
         r_no_match <= (w_final_score < MIN_SCORE);
      end
   end

   assign rom_sel  = r_sel;
   assign rom_addr = r_addr;
   assign img_addr = r_addr;
   assign digit    = r_digit;
   assign score    = r_score;
   assign no_match = r_no_match;

`ifdef DIGIT_SCORES_EN
   logic [SCORE_W-1:0] r_dscore [NUM_DIGITS];

   // Per-digit totals, captured at each digit's last row; only reset clears them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            r_dscore[i] <= 9'd0;
         end
      end else if (r_s1_vld && r_s1_last) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_s1_digit == DIGIT_W'(i)) begin
               r_dscore[i] <= w_total;
            end
         end
      end
   end

   // Readback mux; out-of-range selects read as zero
   always_comb begin
      score_rd = 9'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (score_rd_sel == DIGIT_W'(i)) begin
            score_rd = r_dscore[i];
         end else begin
            score_rd = score_rd;
         end
      end
   end
`endif

endmodule

// File: tb/tb_digit_match_sched.sv
// Self-checking bench for digit_match_sched: seven-segment style glyph ROMs,
// an image buffer and a whole-image reference scorer.
module tb_digit_match_sched;

   localparam int         ND     = 10;
   localparam logic [8:0] TB_MIN = 9'd200;

   logic        clk = 1'b0;
   logic        rst_n, start, abort;
   logic [3:0]  rom_sel, rom_addr, img_addr, digit;
   logic [15:0] tmpl_row, img_row;
   logic        busy, done, no_match;
   logic [8:0]  score;

   logic [15:0] tmpl [16][16];
   logic [15:0] img  [16];

   int checks = 0;
   int errors = 0;

   logic [3:0] prev_d;
   logic [8:0] prev_s;
   logic       prev_nm;

   digit_match_sched #(.NUM_DIGITS(ND), .MIN_SCORE(TB_MIN)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .rom_sel(rom_sel), .rom_addr(rom_addr), .tmpl_row(tmpl_row),
      .img_addr(img_addr), .img_row(img_row), .busy(busy), .done(done),
      .digit(digit), .score(score), .no_match(no_match)
   );

   always #5 clk = ~clk;

   always_comb tmpl_row = tmpl[rom_sel][rom_addr];
   always_comb img_row  = img[img_addr];

   function automatic logic [15:0] glyph_row(input int d, input int r);
      logic [6:0]  s;
      logic [15:0] v;
      case (d)
         0: s = 7'h3F;  1: s = 7'h06;  2: s = 7'h5B;  3: s = 7'h4F;  4: s = 7'h66;
         5: s = 7'h6D;  6: s = 7'h7D;  7: s = 7'h07;  8: s = 7'h7F;  9: s = 7'h6F;
         default: s = 7'h00;
      endcase
      v = 16'h0000;
      if (s[0] && (r == 1 || r == 2))   v = v | 16'h1FF8;  // a
      if (s[1] && r >= 1 && r <= 8)     v = v | 16'h1800;  // b
      if (s[2] && r >= 7 && r <= 14)    v = v | 16'h1800;  // c
      if (s[3] && (r == 13 || r == 14)) v = v | 16'h1FF8;  // d
      if (s[4] && r >= 7 && r <= 14)    v = v | 16'h0018;  // e
      if (s[5] && r >= 1 && r <= 8)     v = v | 16'h0018;  // f
      if (s[6] && (r == 7 || r == 8))   v = v | 16'h1FF8;  // g
      return v;
   endfunction

   task automatic load_glyphs();
      for (int d = 0; d < 16; d++)
         for (int r = 0; r < 16; r++)
            tmpl[d][r] = (d < ND) ? glyph_row(d, r) : 16'h0000;
   endtask

   task automatic set_img_glyph(input int d);
      for (int r = 0; r < 16; r++) img[r] = tmpl[d][r];
   endtask

   // Whole-image reference: count agreeing pixels per digit, strictly greater wins
   task automatic model_best(output logic [3:0] md, output logic [8:0] ms, output logic mnm);
      int bs, bd, tot;
      logic [15:0] x;
      bs = 0; bd = 0;
      for (int k = 0; k < ND; k++) begin
         tot = 0;
         for (int r = 0; r < 16; r++) begin
            x = ~(tmpl[k][r] ^ img[r]);
            tot += $countones(x);
         end
         if (tot > bs) begin bs = tot; bd = k; end
      end
      md = 4'(bd); ms = 9'(bs); mnm = (ms < TB_MIN);
   endtask

   // Launches a scan (sampling edge = edge 0, cycle 1 follows it) and watches it.
   task automatic run_scan(input int pulse_at, input int abort_at, input bit hold,
                           input int window, input int probe_cyc,
                           output int first_done, output int last_done, output int pulses,
                           output logic probe_busy, output logic [3:0] probe_addr);
      first_done = -1; last_done = -1; pulses = 0;
      probe_busy = 1'bx; probe_addr = 4'hx;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 1; cyc <= window; cyc++) begin
         if (done) begin
            pulses++;
            if (first_done < 0) first_done = cyc;
            last_done = cyc;
         end
         if (cyc == probe_cyc) begin probe_busy = busy; probe_addr = rom_addr; end
         start = (cyc == pulse_at) || (hold && cyc >= 150 && cyc <= 162);
         abort = (cyc == abort_at);
         @(posedge clk); #1;
      end
      start = 1'b0; abort = 1'b0;
   endtask

   task automatic check_result(input string tag, input logic [3:0] ed, input logic [8:0] es, input logic enm);
      checks++;
      if (digit !== ed) begin errors++; $display("FAIL %s digit: got %0d expected %0d", tag, digit, ed); end
      checks++;
      if (score !== es) begin errors++; $display("FAIL %s score: got %0d expected %0d", tag, score, es); end
      checks++;
      if (no_match !== enm) begin errors++; $display("FAIL %s no_match: got %0b expected %0b", tag, no_match, enm); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      #13 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset busy/done: got %b%b expected 00", busy, done); end
      checks++;
      if (rom_sel !== 4'd0 || rom_addr !== 4'd0 || img_addr !== 4'd0) begin
         errors++; $display("FAIL reset addr: got sel=%0d addr=%0d img=%0d expected 0", rom_sel, rom_addr, img_addr);
      end
      check_result("reset", 4'd0, 9'd0, 1'b1);
   endtask

   task automatic test_glyph6();
      int fd, ld, np; logic pb; logic [3:0] pa;
      set_img_glyph(6);
      run_scan(-1, -1, 1'b0, 170, 2, fd, ld, np, pb, pa);
      checks++;
      if (fd !== 162) begin errors++; $display("FAIL glyph6 done_cycle: got %0d expected 162", fd); end
      checks++;
      if (np !== 1) begin errors++; $display("FAIL glyph6 done_pulses: got %0d expected 1", np); end
      checks++;
      if (pb !== 1'b1 || pa !== 4'd1) begin errors++; $display("FAIL glyph6 cycle2: got busy=%b addr=%0d expected busy=1 addr=1", pb, pa); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL glyph6 busy_after: got %b expected 0", busy); end
      check_result("glyph6", 4'd6, 9'd256, 1'b0);
      prev_d = 4'd6; prev_s = 9'd256; prev_nm = 1'b0;
   endtask

   task automatic test_tie();
      int fd, ld, np; logic pb; logic [3:0] pa;
      for (int r = 0; r < 16; r++) tmpl[7][r] = tmpl[3][r];
      set_img_glyph(3);
      run_scan(-1, -1, 1'b0, 170, -1, fd, ld, np, pb, pa);
      checks++;
      if (fd !== 162) begin errors++; $display("FAIL tie done_cycle: got %0d expected 162", fd); end
      check_result("tie", 4'd3, 9'd256, 1'b0);
      load_glyphs();
      prev_d = 4'd3; prev_s = 9'd256; prev_nm = 1'b0;
   endtask

   task automatic test_min_score();
      int pos[$]; int j, t, fd, ld, np; logic pb; logic [3:0] pa; bit same;
      for (int p = 0; p < 256; p++) begin
         same = 1'b1;
         for (int k = 1; k < ND; k++)
            if (tmpl[k][p / 16][p % 16] !== tmpl[0][p / 16][p % 16]) same = 1'b0;
         if (same) pos.push_back(p);
      end
      checks++;
      if (pos.size() < 70) begin errors++; $display("FAIL minscore common_pixels: got %0d expected >=70", pos.size()); end
      for (int i = pos.size() - 1; i > 0; i--) begin
         j = $urandom_range(i); t = pos[i]; pos[i] = pos[j]; pos[j] = t;
      end
      set_img_glyph(2);
      for (int i = 0; i < 70 && i < pos.size(); i++)
         img[pos[i] / 16][pos[i] % 16] = ~img[pos[i] / 16][pos[i] % 16];
      run_scan(-1, -1, 1'b0, 170, -1, fd, ld, np, pb, pa);
      checks++;
      if (fd !== 162) begin errors++; $display("FAIL minscore done_cycle: got %0d expected 162", fd); end
      check_result("minscore", 4'd2, 9'd186, 1'b1);
   endtask

   task automatic test_start_ignored();
      int fd, ld, np; logic pb; logic [3:0] pa;
      set_img_glyph(6);
      run_scan(50, -1, 1'b0, 200, -1, fd, ld, np, pb, pa);
      checks++;
      if (fd !== 162 || np !== 1) begin errors++; $display("FAIL start_ignored done: got cycle=%0d pulses=%0d expected 162/1", fd, np); end
      check_result("start_ignored", 4'd6, 9'd256, 1'b0);
   endtask

   task automatic test_back_to_back();
      int fd, ld, np; logic pb; logic [3:0] pa;
      logic [3:0] md; logic [8:0] ms; logic mnm;
      set_img_glyph(8);
      model_best(md, ms, mnm);
      run_scan(-1, -1, 1'b1, 340, 164, fd, ld, np, pb, pa);
      checks++;
      if (fd !== 162 || ld !== 324 || np !== 2) begin
         errors++; $display("FAIL back_to_back done: got %0d/%0d/%0d expected 162/324/2", fd, ld, np);
      end
      checks++;
      if (pb !== 1'b1 || pa !== 4'd1) begin errors++; $display("FAIL back_to_back rescan: got busy=%b addr=%0d expected 1/1", pb, pa); end
      check_result("back_to_back", md, ms, mnm);
      prev_d = md; prev_s = ms; prev_nm = mnm;
   endtask

   task automatic test_abort();
      int fd, ld, np; logic pb; logic [3:0] pa;
      for (int r = 0; r < 16; r++) img[r] = 16'($urandom);
      run_scan(-1, 80, 1'b0, 200, 81, fd, ld, np, pb, pa);
      checks++;
      if (np !== 0) begin errors++; $display("FAIL abort done_pulses: got %0d expected 0", np); end
      checks++;
      if (pb !== 1'b0 || pa !== 4'd0) begin errors++; $display("FAIL abort idle: got busy=%b addr=%0d expected 0/0", pb, pa); end
      check_result("abort_keeps", prev_d, prev_s, prev_nm);
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL start_abort_same busy: got %b expected 0", busy); end
   endtask

   task automatic test_reset_mid();
      int fd, ld, np; logic pb; logic [3:0] pa;
      logic [3:0] md; logic [8:0] ms; logic mnm;
      set_img_glyph(5);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (99) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || rom_sel !== 4'd0 || rom_addr !== 4'd0) begin
         errors++; $display("FAIL reset_mid ctrl: got busy=%b done=%b sel=%0d addr=%0d expected 0", busy, done, rom_sel, rom_addr);
      end
      check_result("reset_mid", 4'd0, 9'd0, 1'b1);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      set_img_glyph(9);
      model_best(md, ms, mnm);
      run_scan(-1, -1, 1'b0, 170, -1, fd, ld, np, pb, pa);
      checks++;
      if (fd !== 162) begin errors++; $display("FAIL after_reset done_cycle: got %0d expected 162", fd); end
      check_result("after_reset", md, ms, mnm);
   endtask

   task automatic test_random();
      int fd, ld, np, nflip, rr, cc; logic pb; logic [3:0] pa;
      logic [3:0] md; logic [8:0] ms; logic mnm;
      for (int n = 0; n < 4; n++) begin
         if (n < 2) begin
            for (int r = 0; r < 16; r++) img[r] = 16'($urandom);
         end else begin
            set_img_glyph($urandom_range(ND - 1));
            nflip = $urandom_range(40);
            for (int f = 0; f < nflip; f++) begin
               rr = $urandom_range(15); cc = $urandom_range(15);
               img[rr][cc] = ~img[rr][cc];
            end
         end
         model_best(md, ms, mnm);
         run_scan(-1, -1, 1'b0, 170, -1, fd, ld, np, pb, pa);
         checks++;
         if (fd !== 162) begin errors++; $display("FAIL random%0d done_cycle: got %0d expected 162", n, fd); end
         check_result($sformatf("random%0d", n), md, ms, mnm);
      end
   endtask

   initial begin
      load_glyphs();
      for (int r = 0; r < 16; r++) img[r] = 16'h0000;
      test_reset();
      test_glyph6();
      test_tie();
      test_min_score();
      test_start_ignored();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
